// File: rtl/mem_pkg.sv
// Shared constants, word type and parity helper for the 32x16 data memory.
package mem_pkg;

    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 16;
    localparam int MEM_DEPTH  = 32;

    typedef logic [MEM_DATA_W-1:0] mem_word_t;

    // Even parity: the stored bit makes the XOR of data and parity equal to zero.
    function automatic logic parity_of(mem_word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Single-port data memory: synchronous write, combinational read, async active-high clear.
// Optional MEM_PARITY_EN adds a stored even-parity bit per word and a parity_err output.
module data_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] WD,
    input  logic              WE,
`ifdef MEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic [DATA_W-1:0] Memout
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (WE) begin
            r_mem[adr] <= WD;
        end
    end

    // Array is already zero under reset; the gate keeps the output clean during assertion.
    assign Memout = rst ? '0 : r_mem[adr];

`ifdef MEM_PARITY_EN
    logic [DEPTH-1:0] r_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= '0;
        end else if (WE) begin
            r_par[adr] <= parity_of(mem_word_t'(WD));
        end
    end

    assign parity_err = rst ? 1'b0 : ((^r_mem[adr]) ^ r_par[adr]);
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus random traffic against an array model.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst;
    logic [4:0]  adr;
    logic [15:0] WD;
    logic        WE;
    logic [15:0] Memout;
`ifdef MEM_PARITY_EN
    logic        parity_err;
`endif

    logic [15:0] model [32];
    int n_chk  = 0;
    int n_pass = 0;

    data_memory dut (
        .clk    (clk),
        .rst    (rst),
        .adr    (adr),
        .WD     (WD),
        .WE     (WE),
`ifdef MEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .Memout (Memout)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    endtask

    // Combinational read: change address, settle, compare against the model.
    task automatic rd(input string tag, input int a);
        adr = 5'(a);
        #1;
        chk(tag, Memout, model[a]);
`ifdef MEM_PARITY_EN
        chk({tag, "_par"}, {15'd0, parity_err}, 16'd0);
`endif
    endtask

    // One clocked access: drive at negedge, check old contents, clock, check new contents.
    task automatic step(input string tag, input logic we, input int a, input logic [15:0] d);
        @(negedge clk);
        WE = we; adr = 5'(a); WD = d;
        #1;
        chk({tag, "_pre"}, Memout, model[a]);
        @(posedge clk);
        if (we) model[a] = d;
        #1;
        chk({tag, "_post"}, Memout, model[a]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    endtask

    initial begin
        int a;
        logic [15:0] d;
        logic we;

        // Reset with no clock edges.
        rst = 1'b1; WE = 1'b0; WD = 16'h0; adr = '0;
        clear_model();
        #3;
        rd("rst_a0", 0);
        rd("rst_a1", 1);
        rd("rst_a31", 31);
        rst = 1'b0;
        #2;
        for (int i = 0; i < 32; i++) rd("post_rst_all", i);

        clk_en = 1'b1;

        // Write / read back.
        step("wr_a0", 1'b1, 0, 16'hA5A5);
        step("wr_a1", 1'b1, 1, 16'h5A5A);
        @(negedge clk);
        WE = 1'b0;
        rd("rb_a0", 0);
        rd("rb_a1", 1);

        // WE low leaves memory untouched.
        for (int i = 0; i < 4; i++) step("we_low", 1'b0, 0, 16'hFFFF);
        rd("we_low_a0", 0);

        // Read-during-write at a fresh address.
        step("rdw_a2", 1'b1, 2, 16'h5A5A);
        @(negedge clk);
        WE = 1'b0;
        rd("rdw_keep_a0", 0);
        rd("rdw_keep_a1", 1);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            a  = int'($urandom_range(0, 31));
            d  = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            step("rand", we, a, d);
        end

        // Async reset pulse between edges.
        @(negedge clk);
        WE = 1'b0;
        step("pre_rst_wr", 1'b1, 7, 16'h1234);
        @(negedge clk);
        WE = 1'b0; adr = 5'd7;
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        chk("rst_mid_drop", Memout, 16'h0000);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) rd("rst_mid_all", i);
        step("post_rst_wr", 1'b1, 31, 16'hBEEF);
        @(negedge clk);
        WE = 1'b0;
        rd("post_rst_rb", 31);

`ifdef MEM_PARITY_EN
        step("par_wr", 1'b1, 3, 16'h0001);
        @(negedge clk);
        WE = 1'b0;
        rd("par_a3", 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
